mux_arb_rr: RTL
===============

# mux_arb_rr

Parametrised successor to the fixed 2:1 datapath select. It arbitrates CHANNELS valid/ready input channels of WIDTH bits onto one registered output. Selection is round-robin or fixed-priority, chosen at run time. The block sits on the write-back and destination-register paths, where more than one producer can present a value in the same cycle and the consumer can stall.

## Interface
Parameters:
- WIDTH, 5 — data bits per channel.
- CHANNELS, 2 — number of input channels; legal range is 2 to 16.
- CW, $clog2(CHANNELS) — channel-index width; derived, not overridden.

Ports:
- clk  input  1  — single clock, rising edge.
- reset  input  1  — synchronous, active-high reset.
- mode  input  1  — selection mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid  input  CHANNELS  — per-channel request.
- in_data  input  CHANNELS*WIDTH  — flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  — one-hot or zero; channel i is accepted in a cycle where in_valid[i] && in_ready[i].
- out_valid  output  1  — output register holds data.
- out_data  output  WIDTH  — registered selected data.
- out_chan  output  CW  — index of the channel that supplied out_data.
- out_ready  input  1  — consumer accepts out_data when out_valid && out_ready.

## Operation
- load_en = !out_valid || out_ready. The output register can take new data only when load_en is 1.
- Grant logic:
  - When load_en is 1 and any in_valid bit is set, exactly one grant index g is chosen and in_ready = one-hot(g).
  - Otherwise in_ready = 0.
  - in_ready depends combinationally on in_valid, mode, out_valid, out_ready and the pointer. It never depends on in_data.
- Fixed mode: g = lowest i with in_valid[i] = 1.
- Round-robin mode: g = first i with in_valid[i] = 1, searching from (last+1) mod CHANNELS upward with wrap.
- last pointer (CW bits):
  - Updated to g on every grant, in both modes.
  - Unchanged when there is no grant.
  - A mode switch therefore takes effect on the next grant, with no extra state.
- On a grant: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- When load_en is 1 and there is no grant: out_valid <= 0. out_data and out_chan hold their old values, which are don't-care.
- When load_en is 0: out_valid, out_data and out_chan hold, and in_ready = 0.
- Simultaneous pop and push (out_valid && out_ready with a pending request): the new grant loads in the same cycle. No bubble.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, last = CHANNELS-1, so channel 0 has first round-robin priority. in_ready = 0 during the reset cycle.
- Reset mid-operation: any held output is dropped. A request granted in the reset cycle is not accepted, because in_ready is forced to 0.
- Latency: an accepted input appears on out_data/out_valid on the next rising edge (1 cycle).
- Throughput: 1 transfer per cycle while out_ready = 1.
- Backpressure: out_valid is held high until out_ready is seen. out_data and out_chan must not change while out_valid && !out_ready.
- Fairness: in round-robin mode with all channels continuously valid, each channel is granted once in every CHANNELS consecutive grants.
- Fixed mode may starve higher indices; this is the intended behaviour.

## Structure
- Shared package mux_arb_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - CHANNELS_MAX = 16.
- Sub-module arb_pick: a combinational priority search. Inputs are the request vector and a start index. Outputs are the grant index and an any-valid flag.
  - Fixed mode drives start = 0.
  - Round-robin mode drives start = last+1 with wrap.
- mux_arb_rr contains the last pointer, the output register and the load_en/in_ready logic.

## Test plan
- Reset, default parameters: assert reset for 2 cycles with in_valid = 2'b11 → out_valid = 0, out_data = 0, out_chan = 0, in_ready = 0. First grant after release goes to channel 0.
- Round-robin alternation: WIDTH = 5, CHANNELS = 2, mode = 1, in_valid = 2'b11, data 5'h0A (ch0) and 5'h15 (ch1), out_ready = 1 → output sequence 0A, 15, 0A, 15 with out_chan 0, 1, 0, 1, one item per cycle.
- Fixed priority: mode = 0, same stimulus → every output is 5'h0A with out_chan = 0. in_ready[1] is never asserted.
- Backpressure: hold out_ready = 0 for 3 cycles after the first grant → out_data and out_chan are stable and in_ready = 2'b00. On out_ready = 1 the next grant loads in the same cycle.
- Wrap-around, CHANNELS = 4, mode = 1: in_valid = 4'b1001, last = 3 → grants alternate 0, 3, 0, 3. Then raise in_valid to 4'b1111 after a grant to 3 → grants follow 0, 1, 2, 3.
- Reset mid-operation: assert reset while out_valid = 1 and out_ready = 0 → next cycle out_valid = 0, last = CHANNELS-1, and the following grant goes to channel 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants for the valid/ready arbitrating output mux.
// Mode encodings and the supported channel ceiling live here.
package mux_arb_pkg;

    localparam logic MODE_FIXED   = 1'b0;
    localparam logic MODE_RR      = 1'b1;
    localparam int   CHANNELS_MAX = 16;

endpackage

// File: rtl/arb_pick.sv
// Combinational priority search: the first set request at or after 'start',
// wrapping round to index 0.
module arb_pick #(
    parameter  int CHANNELS = 2,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CW-1:0]       start,
    output logic [CW-1:0]       grant,
    output logic                any_valid
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
        grant     = '0;
        any_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            int idx;
            idx = (int'(start) + k) % CHANNELS;
            if (!any_valid && req[idx]) begin
                grant     = CW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// Arbitrates CHANNELS valid/ready inputs onto one registered output, choosing
// fixed priority or round-robin at run time.
module mux_arb_rr
    import mux_arb_pkg::*;
#(
    parameter  int WIDTH    = 5,
    parameter  int CHANNELS = 2,
    localparam int CW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    input  logic                      out_ready
);

    logic [CW-1:0]    last;
    logic [CW-1:0]    start;
    logic [CW-1:0]    grant;
    logic             any_valid;
    logic             load_en;
    logic             take;
    logic [WIDTH-1:0] sel_data;

    assign load_en = !out_valid || out_ready;
    // Reset gates acceptance so nothing is consumed from a producer in the reset cycle.
    assign take    = load_en && any_valid && !reset;

    always_comb begin
        start = '0;
        if (mode == MODE_RR) begin
            start = (last == CW'(CHANNELS - 1)) ? '0 : last + 1'b1;
        end
    end

    arb_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .req       (in_valid),
        .start     (start),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == CW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            last      <= CW'(CHANNELS - 1);
        end else if (load_en) begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_chan  <= grant;
                last      <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
